cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Parametrised coprocessor-0 for the single-cycle MIPS core.
- Holds SR, Cause, EPC and PRId.
- Arbitrates synchronous exceptions against HWINT_N masked hardware interrupts, asserts the take-exception request, and records EPC/BD/ExcCode.
- Sits beside the datapath register file; the controller consumes req and exl_clr.

Parameters:
HWINT_N, 5, number of external interrupt lines (1..5), mapped to Cause.IP/SR.IM bits 10..(9+HWINT_N).
PRID, 32'h4A4E_5801, constant value returned for register 15.

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
en  input  1  mtc0 write enable
addr  input  5  CP0 register index (rd field) for read and write
wdata  input  32  mtc0 write data
rdata  output  32  combinational read of register addr
pc  input  32  PC of the instruction currently executing
bd  input  1  current instruction is in a branch delay slot
exc_code_in  input  5  synchronous exception code; 0 = none
hwint  input  HWINT_N  level-sensitive external interrupt lines
exl_clr  input  1  eret executing
req  output  1  exception/interrupt taken this cycle (combinational)
epc_out  output  32  current EPC, for eret target
exl  output  1  current SR.EXL

Behaviour:
- Register map:
  - 12 SR: IM at [10+:HWINT_N] plus [15] when the timer is built; EXL [1]; IE [0]; other bits read 0.
  - 13 Cause: BD [31]; IP mirrors IM positions; ExcCode [6:2]; other bits read 0. Read-only to mtc0.
  - 14 EPC: writable; low 2 bits are always stored as 0.
  - 15 PRId: returns PRID; read-only.
  - Other addresses read 0; writes to them are ignored.
- Reset (async, while reset=1): SR=0, Cause=0, EPC=0, req=0. Outputs: rdata reflects these values, epc_out=0, exl=0.
- Pending: int_pend = SR.IE & |(IP_live & SR.IM), where IP_live is the live hwint (plus timer pending when built).
- Request: req = !SR.EXL & (int_pend | exc_code_in!=0).
  - Interrupt has priority over a simultaneous synchronous exception.
  - req is combinational, so the controller redirects NPC in the same cycle.
- On a clock edge with req=1:
  - EXL<=1.
  - ExcCode<= int_pend ? 0 : exc_code_in.
  - BD<=bd.
  - EPC<= bd ? {pc[31:2],2'b00}-4 : {pc[31:2],2'b00}.
- Cause.IP is registered from the interrupt sources every cycle, independent of req.
- On a clock edge with exl_clr=1 and req=0: EXL<=0.
- mtc0 (en=1) takes effect at the clock edge only if req=0; if req=1 the write is dropped, because the faulting/interrupted instruction commits nothing.
- Simultaneous exl_clr and en writing SR: write data applied first, then EXL forced to 0.
- While EXL=1, all exceptions and interrupts are ignored (req=0). Nested exceptions are not supported.
- EPC arithmetic wraps modulo 2^32 (bd with pc=0 gives FFFF_FFFC).

Optional Feature:
Macro CP0_TIMER_EN.
- Defined:
  - Adds Count (reg 9) and Compare (reg 11). Reset values: Count 0, Compare FFFF_FFFF.
  - Count increments every cycle, wraps, and is writable.
  - When Count==Compare, timer-pending latches into Cause.IP[15]; it is masked by SR.IM[15] and contributes to int_pend.
  - An mtc0 to Compare clears timer-pending.
- Undefined: regs 9/11 read 0, bit 15 of IP/IM reads 0, no timer logic.

Test Plan:
1. Reset mid-run with SR=0x0000_0C01, EPC=0x3000 -> immediately after reset: SR=0, Cause=0, EPC=0, req=0, exl=0.
2. mtc0 SR=0x0000_0401 (IM0, IE), hwint=5'b00001, pc=0x3008, bd=0 -> req=1 same cycle; next edge: EPC=0x3008, ExcCode=0, EXL=1, Cause.IP[10]=1; further cycles req=0.
3. exc_code_in=4 (AdEL), bd=1, pc=0x3010, IE=0 -> req=1; EPC=0x300C, Cause=0x8000_0010.
4. Interrupt and exc_code_in=12 asserted together with IE=1 -> ExcCode=0 (interrupt wins); same cycle en=1 to EPC=0x1234 -> EPC holds the pc value, write dropped.
5. EXL=1, exl_clr=1 and en writing SR=0x0000_0403 in one cycle -> SR reads 0x0000_0401. Pending hwint then raises req on the next cycle.
6. CP0_TIMER_EN: Compare=5, SR=0x0000_8001 -> req asserts when Count reaches 5; mtc0 Compare clears Cause.IP[15]. Without the macro, reading reg 11 returns 0.

Source files
------------

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - MIPS coprocessor 0: SR/Cause/EPC/PRId, exception and interrupt arbitration.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_unit #(
    parameter int          HWINT_N = 5,
    parameter logic [31:0] PRID    = 32'h4A4E_5801
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [4:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic [31:0]        pc,
    input  logic               bd,
    input  logic [4:0]         exc_code_in,
    input  logic [HWINT_N-1:0] hwint,
    input  logic               exl_clr,
    output logic               req,
    output logic [31:0]        epc_out,
    output logic               exl
);

    logic [HWINT_N-1:0] sr_im_q, cause_ip_q;
    logic               sr_exl_q, sr_ie_q, cause_bd_q;
    logic [4:0]         cause_exc_q;
    logic [31:0]        epc_q, epc_d;
    logic [31:0]        im_vec, ip_live, sr_val, cause_val;
    logic               int_pend, wr_ok;
    logic               tim_im, tim_pend;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, compare_q;
    logic        tpend_q, sr_im15_q;

    assign tim_im   = sr_im15_q;
    assign tim_pend = tpend_q;

    // A Compare write acknowledges the timer; otherwise a match latches pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= 32'h0;
            compare_q <= 32'hFFFF_FFFF;
            tpend_q   <= 1'b0;
            sr_im15_q <= 1'b0;
        end else begin
            count_q <= (wr_ok && addr == 5'd9) ? wdata : count_q + 32'd1;
            if (wr_ok && addr == 5'd11) begin
                compare_q <= wdata;
                tpend_q   <= 1'b0;
            end else if (count_q == compare_q) begin
                tpend_q <= 1'b1;
            end
            if (wr_ok && addr == 5'd12) sr_im15_q <= wdata[15];
        end
    end
`else
    assign tim_im   = 1'b0;
    assign tim_pend = 1'b0;
`endif

    always_comb begin
        im_vec                = '0;
        im_vec[10+:HWINT_N]   = sr_im_q;
        im_vec[15]            = tim_im;
        ip_live               = '0;
        ip_live[10+:HWINT_N]  = hwint;
        ip_live[15]           = tim_pend;
        sr_val                = im_vec;
        sr_val[1]             = sr_exl_q;
        sr_val[0]             = sr_ie_q;
        cause_val             = '0;
        cause_val[31]         = cause_bd_q;
        cause_val[10+:HWINT_N] = cause_ip_q;
        cause_val[15]         = tim_pend;
        cause_val[6:2]        = cause_exc_q;
    end

    assign int_pend = sr_ie_q & (|(ip_live & im_vec));
    assign req      = !reset & !sr_exl_q & (int_pend | (|exc_code_in));
    assign wr_ok    = en & !req;
    assign epc_d    = (pc & 32'hFFFF_FFFC) - (bd ? 32'd4 : 32'd0);
    assign epc_out  = epc_q;
    assign exl      = sr_exl_q;

    always_comb begin
        rdata = 32'h0;
        case (addr)
`ifdef CP0_TIMER_EN
            5'd9:  rdata = count_q;
            5'd11: rdata = compare_q;
`endif
            5'd12: rdata = sr_val;
            5'd13: rdata = cause_val;
            5'd14: rdata = epc_q;
            5'd15: rdata = PRID;
            default: rdata = 32'h0;
        endcase
    end

    // A taken exception commits nothing from the faulting instruction, so mtc0 is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_ip_q  <= '0;
            cause_bd_q  <= 1'b0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'h0;
        end else begin
            cause_ip_q <= hwint;
            if (req) begin
                sr_exl_q    <= 1'b1;
                cause_exc_q <= int_pend ? 5'd0 : exc_code_in;
                cause_bd_q  <= bd;
                epc_q       <= epc_d;
            end else begin
                if (en && addr == 5'd12) begin
                    sr_im_q  <= wdata[10+:HWINT_N];
                    sr_exl_q <= wdata[1];
                    sr_ie_q  <= wdata[0];
                end
                if (en && addr == 5'd14) epc_q <= wdata & 32'hFFFF_FFFC;
                if (exl_clr) sr_exl_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - directed and randomized checks of cp0_unit against a register-level model.
module tb_cp0_unit;
    localparam int          HW   = 5;
    localparam logic [31:0] PRID = 32'h4A4E_5801;
`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif
    localparam logic [31:0] IMMASK = ((32'd1 << HW) - 32'd1) << 10 | (TIMER ? 32'h8000 : 32'h0);
    localparam logic [31:0] SRMASK = IMMASK | 32'h3;

    logic          clk = 1'b0;
    logic          reset, en, bd, exl_clr;
    logic [4:0]    addr, exc;
    logic [31:0]   wdata, pc;
    logic [HW-1:0] hwint;
    logic [31:0]   rdata, epc_out;
    logic          req, exl;

    int total = 0;
    int bad   = 0;

    cp0_unit #(.HWINT_N(HW), .PRID(PRID)) dut (
        .clk(clk), .reset(reset), .en(en), .addr(addr), .wdata(wdata), .rdata(rdata),
        .pc(pc), .bd(bd), .exc_code_in(exc), .hwint(hwint), .exl_clr(exl_clr),
        .req(req), .epc_out(epc_out), .exl(exl)
    );

    always #5 clk = ~clk;

    // Register-level model: whole 32-bit architectural registers with masks.
    logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
    logic        m_tp;
    logic [31:0] ip_live, ipbits, exp_rd;
    logic        exp_pend, exp_req;

    always_comb begin
        ipbits   = 32'(hwint) << 10;
        ip_live  = ipbits | ((TIMER && m_tp) ? 32'h8000 : 32'h0);
        exp_pend = m_sr[0] && ((ip_live & m_sr & IMMASK) != 32'h0);
        exp_req  = !reset && !m_sr[1] && (exp_pend || exc != 5'd0);
        case (addr)
            5'd9:    exp_rd = TIMER ? m_count : 32'h0;
            5'd11:   exp_rd = TIMER ? m_compare : 32'h0;
            5'd12:   exp_rd = m_sr;
            5'd13:   exp_rd = m_cause | ((TIMER && m_tp) ? 32'h8000 : 32'h0);
            5'd14:   exp_rd = m_epc;
            5'd15:   exp_rd = PRID;
            default: exp_rd = 32'h0;
        endcase
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_sr <= 0; m_cause <= 0; m_epc <= 0;
            m_count <= 0; m_compare <= 32'hFFFF_FFFF; m_tp <= 0;
        end else begin
            if (exp_req) begin
                m_sr    <= m_sr | 32'h2;
                m_cause <= (bd ? 32'h8000_0000 : 32'h0) | ipbits | (exp_pend ? 32'h0 : 32'(exc) << 2);
                m_epc   <= (pc & ~32'h3) - (bd ? 32'd4 : 32'd0);
            end else begin
                m_cause <= (m_cause & 32'h8000_007C) | ipbits;
                m_sr    <= ((en && addr == 12) ? (wdata & SRMASK) : m_sr) & (exl_clr ? ~32'h2 : ~32'h0);
                if (en && addr == 14) m_epc <= wdata & ~32'h3;
            end
            if (TIMER) begin
                m_count <= (en && !exp_req && addr == 9) ? wdata : m_count + 1;
                if (en && !exp_req && addr == 11) begin
                    m_compare <= wdata;
                    m_tp      <= 0;
                end else if (m_count == m_compare) m_tp <= 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("req", 32'(req), 32'(exp_req));
        chk("exl", 32'(exl), 32'(m_sr[1]));
        chk("epc_out", epc_out, m_epc);
        chk("rdata", rdata, exp_rd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [4:0] a, input logic [31:0] d, input logic c);
        en = e; addr = a; wdata = d; exl_clr = c;
    endtask

    task automatic rd(input logic [4:0] a, input string name, input logic [31:0] expv);
        addr = a;
        #1;
        chk(name, rdata, expv);
    endtask

    initial begin
        reset = 1; en = 0; addr = 0; wdata = 0; pc = 0; bd = 0; exc = 0; hwint = 0; exl_clr = 0;
        tick(); tick();
        reset = 0;

        // Reset in the middle of a run
        drive(1, 12, 32'h0000_0C01, 0); tick();
        drive(1, 14, 32'h0000_3000, 0); tick();
        drive(0, 0, 0, 0);
        chk("epc_pre_reset", epc_out, 32'h3000);
        reset = 1; exc = 5'd4;
        #1;
        chk("reset_req", 32'(req), 0);
        chk("reset_exl", 32'(exl), 0);
        chk("reset_epc", epc_out, 0);
        rd(12, "reset_sr", 0);
        rd(13, "reset_cause", 0);
        tick();
        reset = 0; exc = 0;

        // Interrupt taken
        drive(1, 12, 32'h0000_0401, 0); tick();
        drive(0, 0, 0, 0); hwint = 1; pc = 32'h3008; bd = 0;
        #1 chk("int_req", 32'(req), 1);
        tick();
        chk("int_epc", epc_out, 32'h3008);
        chk("int_exl", 32'(exl), 1);
        rd(13, "int_cause", 32'h0000_0400);
        chk("int_masked_by_exl", 32'(req), 0);

        // Synchronous exception in a delay slot, IE=0
        drive(1, 12, 32'h0000_0400, 1); hwint = 0; tick();
        drive(0, 0, 0, 0); exc = 4; bd = 1; pc = 32'h3010;
        #1 chk("adel_req", 32'(req), 1);
        tick();
        exc = 0; bd = 0;
        chk("adel_epc", epc_out, 32'h300C);
        rd(13, "adel_cause", 32'h8000_0010);

        // Interrupt beats exception; concurrent mtc0 EPC dropped
        drive(1, 12, 32'h0000_0401, 1); tick();
        drive(1, 14, 32'h1234, 0); hwint = 1; exc = 12; pc = 32'h4000;
        #1 chk("prio_req", 32'(req), 1);
        tick();
        drive(0, 0, 0, 0); exc = 0;
        chk("prio_epc", epc_out, 32'h4000);
        rd(13, "prio_cause", 32'h0000_0400);

        // eret together with mtc0 SR that sets EXL
        drive(1, 12, 32'h0000_0403, 1);
        #1 chk("eret_req", 32'(req), 0);
        tick();
        drive(0, 0, 0, 0);
        rd(12, "eret_sr", 32'h0000_0401);
        chk("eret_pending_req", 32'(req), 1);
        tick();

`ifdef CP0_TIMER_EN
        hwint = 0;
        drive(1, 12, 32'h0000_8001, 1); tick();
        drive(1, 11, 32'd5, 0); tick();
        drive(1, 9, 32'd0, 0); tick();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 20 && !req; i++) tick();
        chk("timer_req", 32'(req), 1);
        rd(13, "timer_ip", exp_rd | 32'h8000);
        tick();
        drive(1, 11, 32'd5, 0); tick();
        drive(0, 0, 0, 0);
        addr = 13; #1;
        chk("timer_ack", rdata & 32'h8000, 32'h0);
`else
        rd(11, "no_compare", 0);
        rd(9, "no_count", 0);
`endif
        drive(0, 0, 0, 1); hwint = 0; tick();

        for (int n = 0; n < 1500; n++) begin
            int sel;
            sel = int'($urandom_range(0, 7));
            en      = ($urandom_range(0, 3) == 0);
            addr    = (sel < 6) ? 5'(sel + 9) : 5'($urandom);
            wdata   = $urandom;
            exl_clr = ($urandom_range(0, 3) == 0);
            exc     = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            hwint   = HW'($urandom & $urandom & $urandom);
            pc      = $urandom;
            bd      = 1'($urandom);
            if (n == 700) begin
                pc = 0; bd = 1; exc = 4;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at %0t", $time);
        $fatal(1);
    end
endmodule
